// File: rtl/spi_pwm_config_ctrl_if.sv
// spi_pwm_config_ctrl_if: SPI pins in, PWM configuration registers and status pulses out
interface spi_pwm_config_ctrl_if;
  logic       sclk;
  logic       ncs;
  logic       copi;
  logic [7:0] en_reg_out_7_0;
  logic [7:0] en_reg_out_15_8;
  logic [7:0] en_reg_pwm_7_0;
  logic [7:0] en_reg_pwm_15_8;
  logic [7:0] pwm_duty_cycle;
  logic       cfg_update;
  logic       frame_err;
  modport master (
    output sclk, ncs, copi,
    input  en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8,
           pwm_duty_cycle, cfg_update, frame_err
  );
  modport slave (
    input  sclk, ncs, copi,
    output en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8,
           pwm_duty_cycle, cfg_update, frame_err
  );
endinterface

// File: rtl/spi_pwm_config_ctrl.sv
// spi_pwm_config_ctrl: oversampled SPI mode-0 write-only register port driving the PWM configuration
module spi_pwm_config_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_ADDR    = 4
) (
  input logic                  clk,
  input logic                  rst,
  spi_pwm_config_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;
  state_t               state_q;
  logic [SYNC_STAGES:0] sclk_q, ncs_q, copi_q;
  logic [15:0]          shift_q;
  logic [4:0]           cnt_q;
  logic [7:0]           regs_q [5];
  logic                 cfg_update_q, frame_err_q;
  logic                 sclk_rise, ncs_fall, ncs_rise, wr_ok;
  assign sclk_rise = sclk_q[SYNC_STAGES-1] & ~sclk_q[SYNC_STAGES];
  assign ncs_fall  = ~ncs_q[SYNC_STAGES-1] & ncs_q[SYNC_STAGES];
  assign ncs_rise  = ncs_q[SYNC_STAGES-1] & ~ncs_q[SYNC_STAGES];
  // the second address bound keeps a widened MAX_ADDR from pulsing without a real register
  assign wr_ok = (cnt_q == 5'd16) && shift_q[15] && (shift_q[14:8] <= 7'(MAX_ADDR)) && (shift_q[14:8] < 7'd5);
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      sclk_q       <= '0;
      ncs_q        <= '1;
      copi_q       <= '0;
      shift_q      <= '0;
      cnt_q        <= '0;
      cfg_update_q <= 1'b0;
      frame_err_q  <= 1'b0;
      for (int i = 0; i < 5; i++) regs_q[i] <= '0;
    end else begin
      sclk_q       <= {sclk_q[SYNC_STAGES-1:0], bus.sclk};
      ncs_q        <= {ncs_q[SYNC_STAGES-1:0], bus.ncs};
      copi_q       <= {copi_q[SYNC_STAGES-1:0], bus.copi};
      cfg_update_q <= 1'b0;
      frame_err_q  <= 1'b0;
      case (state_q)
        IDLE: if (ncs_fall) begin
          state_q <= SHIFT;
          shift_q <= '0;
          cnt_q   <= '0;
        end
        SHIFT: if (ncs_rise) state_q <= COMMIT;
        else if (sclk_rise) begin
          shift_q <= {shift_q[14:0], copi_q[SYNC_STAGES-1]};
          cnt_q   <= (cnt_q == 5'd17) ? cnt_q : cnt_q + 5'd1;
        end
        default: begin
          state_q <= IDLE;
          if (wr_ok) begin
            for (int i = 0; i < 5; i++) if (shift_q[14:8] == 7'(i)) regs_q[i] <= shift_q[7:0];
            cfg_update_q <= 1'b1;
          end else if (cnt_q != 5'd16) frame_err_q <= 1'b1;
        end
      endcase
    end
  end
  assign bus.en_reg_out_7_0  = regs_q[0];
  assign bus.en_reg_out_15_8 = regs_q[1];
  assign bus.en_reg_pwm_7_0  = regs_q[2];
  assign bus.en_reg_pwm_15_8 = regs_q[3];
  assign bus.pwm_duty_cycle  = regs_q[4];
  assign bus.cfg_update      = cfg_update_q;
  assign bus.frame_err       = frame_err_q;
endmodule

// File: tb/tb_spi_pwm_config_ctrl.sv
// tb_spi_pwm_config_ctrl: scoreboard bench driving SPI frames at sclk = clk/4
module tb_spi_pwm_config_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  spi_pwm_config_ctrl_if ifc ();
  spi_pwm_config_ctrl #(.SYNC_STAGES(2), .MAX_ADDR(4)) dut (.clk(clk), .rst(rst), .bus(ifc.slave));
  always #5 clk = ~clk;
  typedef struct {logic upd; logic err; logic [39:0] regs;} exp_t;
  exp_t       q[$];
  logic [7:0] m [5];
  int         n_chk = 0;
  int         n_fail = 0;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [39:0] model_regs();
    return {m[4], m[3], m[2], m[1], m[0]};
  endfunction
  function automatic logic [39:0] dut_regs();
    return {ifc.pwm_duty_cycle, ifc.en_reg_pwm_15_8, ifc.en_reg_pwm_7_0, ifc.en_reg_out_15_8, ifc.en_reg_out_7_0};
  endfunction
  always @(negedge clk) begin
    if (!rst && (ifc.cfg_update || ifc.frame_err)) begin
      if (q.size() == 0) check("unexpected_pulse", {62'd0, ifc.cfg_update, ifc.frame_err}, 64'd0);
      else begin
        exp_t e;
        e = q.pop_front();
        check("cfg_update", 64'(ifc.cfg_update), 64'(e.upd));
        check("frame_err", 64'(ifc.frame_err), 64'(e.err));
        check("regs_at_pulse", 64'(dut_regs()), 64'(e.regs));
      end
    end
  end
  task automatic bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      ifc.copi = v[i];
      repeat (2) @(negedge clk);
      ifc.sclk = 1'b1;
      repeat (2) @(negedge clk);
      ifc.sclk = 1'b0;
    end
  endtask
  task automatic xfer(input logic [15:0] f, input int n, input int gap);
    logic [31:0] v;
    v = (n >= 16) ? (32'(f) << (n - 16)) : (32'(f) >> (16 - n));
    if (n != 16) q.push_back('{upd: 1'b0, err: 1'b1, regs: model_regs()});
    else if (f[15] && f[14:8] <= 7'd4) begin
      m[f[10:8]] = f[7:0];
      q.push_back('{upd: 1'b1, err: 1'b0, regs: model_regs()});
    end
    ifc.ncs = 1'b0;
    repeat (4) @(negedge clk);
    bits(v, n);
    repeat (2) @(negedge clk);
    ifc.ncs = 1'b1;
    repeat (gap) @(negedge clk);
  endtask
  task automatic settle(input string tag);
    repeat (12) @(negedge clk);
    check({tag, "_pending"}, 64'(q.size()), 64'd0);
    check({tag, "_regs"}, 64'(dut_regs()), 64'(model_regs()));
    q.delete();
  endtask
  initial begin
    ifc.sclk = 1'b0;
    ifc.ncs  = 1'b1;
    ifc.copi = 1'b0;
    for (int i = 0; i < 5; i++) m[i] = 8'h00;
    repeat (2) begin
      @(negedge clk);
      check("rst_cfg_update", 64'(ifc.cfg_update), 64'd0);
      check("rst_frame_err", 64'(ifc.frame_err), 64'd0);
    end
    check("rst_regs", 64'(dut_regs()), 64'd0);
    rst = 1'b0;
    xfer(16'h80FF, 16, 0); settle("wr_out_lo");
    xfer(16'h8480, 16, 0); settle("wr_duty");
    xfer(16'h85AA, 16, 0); settle("bad_addr");
    xfer(16'h00FF, 16, 0); settle("read");
    xfer(16'h8255, 15, 0); settle("short");
    xfer(16'h8255, 17, 0); settle("long");
    check("pwm_lo_untouched", 64'(ifc.en_reg_pwm_7_0), 64'h00);
    ifc.ncs = 1'b0;
    repeat (4) @(negedge clk);
    bits(32'h81, 8);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    ifc.ncs = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) m[i] = 8'h00;
    settle("mid_rst");
    xfer(16'h8133, 16, 0); settle("after_rst");
    check("out_hi", 64'(ifc.en_reg_out_15_8), 64'h33);
    xfer(16'h8201, 16, 4);
    xfer(16'h8302, 16, 0);
    settle("b2b");
    check("pwm_lo", 64'(ifc.en_reg_pwm_7_0), 64'h01);
    check("pwm_hi", 64'(ifc.en_reg_pwm_15_8), 64'h02);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
